// File: rtl/bcd_time_loader.sv
// MM:SS cook timer: BCD digit entry by right-shift in IDLE, 1 Hz BCD countdown in RUN,
// pause/resume/clear via start/stop, and a fixed-length DONE pulse at 00:00.
module bcd_time_loader #(
    parameter int DONE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    mt_reg, mo_reg, st_reg, so_reg;
    logic [3:0]    mt_next, mo_next, st_next, so_next;
    logic [CW-1:0] done_cnt_reg, done_cnt_next;
    logic          loadn_q_reg, tick_q_reg;
    logic          running_reg, done_reg;

    logic          load_event, tick_event, time_zero;
    logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
    logic          borrow_so, borrow_st, borrow_mo, dec_zero;

    assign load_event = loadn_q_reg & ~loadn;
    assign tick_event = ~tick_q_reg & pgt_1Hz;
    assign time_zero  = (mt_reg == 4'd0) && (mo_reg == 4'd0) && (st_reg == 4'd0) && (so_reg == 4'd0);

    // BCD borrow chain; sec_tens wraps to 5 so 6..9 entries simply count down.
    always_comb begin
        borrow_so = (so_reg == 4'd0);
        borrow_st = borrow_so && (st_reg == 4'd0);
        borrow_mo = borrow_st && (mo_reg == 4'd0);
        dec_so    = borrow_so ? 4'd9 : so_reg - 4'd1;
        dec_st    = borrow_so ? (borrow_st ? 4'd5 : st_reg - 4'd1) : st_reg;
        dec_mo    = borrow_st ? (borrow_mo ? 4'd9 : mo_reg - 4'd1) : mo_reg;
        dec_mt    = borrow_mo ? mt_reg - 4'd1 : mt_reg;
        dec_zero  = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
    end

    always_comb begin
        state_next    = state_reg;
        mt_next       = mt_reg;
        mo_next       = mo_reg;
        st_next       = st_reg;
        so_next       = so_reg;
        done_cnt_next = done_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (stop) begin
                    {mt_next, mo_next, st_next, so_next} = 16'h0000;
                end else if (start && !time_zero) begin
                    state_next = RUN;
                end else if (load_event && (D <= 4'd9)) begin
                    {mt_next, mo_next, st_next, so_next} = {mo_reg, st_reg, so_reg, D};
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = PAUSE;
                end else if (tick_event) begin
                    {mt_next, mo_next, st_next, so_next} = {dec_mt, dec_mo, dec_st, dec_so};
                    if (dec_zero) begin
                        state_next    = DONE;
                        done_cnt_next = CW'(DONE_CYCLES - 1);
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                    {mt_next, mo_next, st_next, so_next} = 16'h0000;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (stop || start || (done_cnt_reg == '0)) begin
                    state_next = IDLE;
                end else begin
                    done_cnt_next = done_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mt_reg       <= 4'd0;
            mo_reg       <= 4'd0;
            st_reg       <= 4'd0;
            so_reg       <= 4'd0;
            done_cnt_reg <= '0;
            loadn_q_reg  <= 1'b1;
            tick_q_reg   <= 1'b1;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mt_reg       <= mt_next;
            mo_reg       <= mo_next;
            st_reg       <= st_next;
            so_reg       <= so_next;
            done_cnt_reg <= done_cnt_next;
            loadn_q_reg  <= loadn;
            tick_q_reg   <= pgt_1Hz;
            running_reg  <= (state_next == RUN);
            done_reg     <= (state_next == DONE);
        end
    end

    assign min_tens = mt_reg;
    assign min_ones = mo_reg;
    assign sec_tens = st_reg;
    assign sec_ones = so_reg;
    assign running  = running_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Randomized and directed bench for bcd_time_loader; a per-cycle reference model
// (time held as integer minutes/seconds) feeds a scoreboard checked on the falling edge.
module tb_bcd_time_loader;

    localparam int DONE_CYCLES = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1Hz = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;

    bcd_time_loader #(.DONE_CYCLES(DONE_CYCLES)) dut (
        .clk(clk), .rst(rst), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .start(start), .stop(stop),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic        running;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle_no = 0;

    // Reference model: time as whole minutes and seconds, entry as a 4-digit decimal number.
    int m_min = 0, m_sec = 0, m_mode = M_IDLE, m_lq = 1, m_tq = 1, m_left = 0;

    function automatic logic [15:0] to_bcd(int mins, int secs);
        logic [15:0] r;
        r[15:12] = 4'(mins / 10);
        r[11:8]  = 4'(mins % 10);
        r[7:4]   = 4'(secs / 10);
        r[3:0]   = 4'(secs % 10);
        return r;
    endfunction

    task automatic model_step();
        int le, te, v;
        exp_t e;
        if (rst) begin
            m_min = 0; m_sec = 0; m_mode = M_IDLE; m_lq = 1; m_tq = 1; m_left = 0;
        end else begin
            le = (m_lq == 1 && loadn == 1'b0) ? 1 : 0;
            te = (m_tq == 0 && pgt_1Hz == 1'b1) ? 1 : 0;
            m_lq = int'(loadn);
            m_tq = int'(pgt_1Hz);
            case (m_mode)
                M_IDLE: begin
                    if (stop) begin
                        m_min = 0; m_sec = 0;
                    end else if (start && (m_min + m_sec) != 0) begin
                        m_mode = M_RUN;
                    end else if (le == 1 && D <= 4'd9) begin
                        v = ((m_min * 100 + m_sec) * 10 + int'(D)) % 10000;
                        m_min = v / 100;
                        m_sec = v % 100;
                    end
                end
                M_RUN: begin
                    if (stop) begin
                        m_mode = M_PAUSE;
                    end else if (te == 1) begin
                        if (m_sec > 0) m_sec = m_sec - 1;
                        else begin m_sec = 59; m_min = m_min - 1; end
                        if (m_min == 0 && m_sec == 0) begin
                            m_mode = M_DONE;
                            m_left = DONE_CYCLES;
                        end
                    end
                end
                M_PAUSE: begin
                    if (stop) begin
                        m_mode = M_IDLE; m_min = 0; m_sec = 0;
                    end else if (start) begin
                        m_mode = M_RUN;
                    end
                end
                default: begin
                    if (stop || start) m_mode = M_IDLE;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
            endcase
        end
        e.digits  = to_bcd(m_min, m_sec);
        e.running = (m_mode == M_RUN);
        e.done    = (m_mode == M_DONE);
        sb.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge after each modelled rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({min_tens, min_ones, sec_tens, sec_ones} === e.digits && running === e.running && done === e.done)
                passes++;
            else
                $display("FAIL sb cycle %0d: got digits %h running %b done %b, expected digits %h running %b done %b",
                         cycle_no, {min_tens, min_ones, sec_tens, sec_ones}, running, done,
                         e.digits, e.running, e.done);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        cycle_no++;
        #1;
    endtask

    task automatic check_now(string name, logic [15:0] exp_digits, logic exp_running, logic exp_done);
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} === exp_digits && running === exp_running && done === exp_done) begin
            passes++;
            $display("check %s: digits %h running %b done %b", name, exp_digits, exp_running, exp_done);
        end else
            $display("FAIL %s: got digits %h running %b done %b, expected digits %h running %b done %b",
                     name, {min_tens, min_ones, sec_tens, sec_ones}, running, done,
                     exp_digits, exp_running, exp_done);
    endtask

    task automatic press(logic [3:0] d, int low_cycles);
        D = d;
        loadn = 1'b0;
        repeat (low_cycles) step();
        loadn = 1'b1;
        repeat (2) step();
    endtask

    task automatic tick();
        pgt_1Hz = 1'b1;
        repeat (2) step();
        pgt_1Hz = 1'b0;
        repeat (2) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0; step();
    endtask

    task automatic enter4(logic [15:0] v);
        press(v[15:12], 2); press(v[11:8], 2); press(v[7:4], 2); press(v[3:0], 2);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        check_now("reset", 16'h0000, 1'b0, 1'b0);

        press(4'd1, 2); press(4'd0, 2); press(4'd5, 2);
        check_now("entry_105", 16'h0105, 1'b0, 1'b0);
        press(4'd7, 20);
        check_now("long_press_one_shift", 16'h1057, 1'b0, 1'b0);
        press(4'd12, 2);
        check_now("invalid_digit", 16'h1057, 1'b0, 1'b0);
        pulse_stop();
        check_now("idle_stop_clears", 16'h0000, 1'b0, 1'b0);
        pulse_start();
        check_now("start_at_zero", 16'h0000, 1'b0, 1'b0);

        enter4(16'h0002);
        pulse_start();
        check_now("run_0002", 16'h0002, 1'b1, 1'b0);
        tick();
        check_now("tick1", 16'h0001, 1'b1, 1'b0);
        pgt_1Hz = 1'b1; step();
        check_now("tick2_done", 16'h0000, 1'b0, 1'b1);
        pgt_1Hz = 1'b0;
        repeat (DONE_CYCLES + 2) step();
        check_now("done_expired", 16'h0000, 1'b0, 1'b0);
        tick();
        check_now("tick3_ignored", 16'h0000, 1'b0, 1'b0);

        enter4(16'h0100); pulse_start(); tick();
        check_now("borrow_0100", 16'h0059, 1'b1, 1'b0);
        pulse_stop(); pulse_stop();
        enter4(16'h1000); pulse_start(); tick();
        check_now("borrow_1000", 16'h0959, 1'b1, 1'b0);
        pulse_stop(); pulse_stop();
        enter4(16'h0090); pulse_start(); tick();
        check_now("sec_tens_9", 16'h0089, 1'b1, 1'b0);
        pulse_stop(); pulse_stop();

        enter4(16'h0030); pulse_start();
        pulse_stop(); tick(); tick();
        check_now("pause_holds", 16'h0030, 1'b0, 1'b0);
        pulse_start(); tick();
        check_now("resume_tick", 16'h0029, 1'b1, 1'b0);
        pulse_stop(); pulse_stop();
        check_now("stop_twice", 16'h0000, 1'b0, 1'b0);

        enter4(16'h0010); pulse_start();
        stop = 1'b1; pgt_1Hz = 1'b1; step();
        stop = 1'b0; step(); pgt_1Hz = 1'b0; step();
        check_now("stop_and_tick", 16'h0010, 1'b0, 1'b0);
        pulse_stop();

        enter4(16'h0500); pulse_start();
        rst = 1'b1; step(); rst = 1'b0;
        check_now("reset_in_run", 16'h0000, 1'b0, 1'b0);
        step();

        // Randomized sessions: clear, enter a short time, then random command/tick traffic.
        for (int it = 0; it < 40; it++) begin
            pulse_stop(); pulse_stop();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                press(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
            for (int c = 0; c < 90; c++) begin
                rst   = ($urandom_range(0, 299) == 0);
                start = ($urandom_range(0, 24) == 0);
                stop  = ($urandom_range(0, 49) == 0);
                D     = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) pgt_1Hz = ~pgt_1Hz;
                if ($urandom_range(0, 4) == 0) loadn = ~loadn;
                step();
            end
            rst = 1'b0; start = 1'b0; stop = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0;
            step();
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
